// File: rtl/quic_dec_pkg.sv
// quic_dec_pkg
// Shared definitions for the QUIC decoder bit-window controller: word/buffer
// widths, the consume limit, the controller state encoding and a helper that
// checks a decoder consume request against the limit.
package quic_dec_pkg;

  localparam int QUIC_WORD_W      = 32;
  localparam int QUIC_BUF_W       = 2 * QUIC_WORD_W;
  localparam int QUIC_FILL_W      = 7;
  localparam int QUIC_LEN_W       = 6;
  localparam int QUIC_MAX_CONSUME = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } quic_bitwin_state_e;

  function automatic logic consume_len_legal(input logic [QUIC_LEN_W-1:0] len);
    return len <= QUIC_LEN_W'(QUIC_MAX_CONSUME);
  endfunction

endpackage

// File: rtl/quic_dec_bitwin_ctrl_if.sv
// quic_dec_bitwin_ctrl_if
// Input word stream into the bit-window controller.
//   in_valid  word valid (source)
//   in_data   32-bit word, first stream bit in bit 31 (source)
//   in_last   final word of the stream, meaningful on a transfer (source)
//   in_ready  controller can take a word this cycle (sink)
// master: word source; slave: the controller.
interface quic_dec_bitwin_ctrl_if;
  import quic_dec_pkg::*;

  logic                   in_valid;
  logic [QUIC_WORD_W-1:0] in_data;
  logic                   in_last;
  logic                   in_ready;

  modport master (output in_valid, output in_data, output in_last, input in_ready);
  modport slave  (input in_valid, input in_data, input in_last, output in_ready);

endinterface

// File: rtl/quic_bitbuf_shift.sv
// quic_bitbuf_shift
// Combinational shift/merge datapath for the 64-bit left-aligned bit buffer.
// Drops c bits from the top, then (when load is set) appends a 32-bit word
// directly after the bits that remain.
//   buf_cur    current buffer, next stream bit in bit 63
//   fill       valid bits in buf_cur (0..64)
//   c          bits consumed this cycle (0..32)
//   in_data    word to append
//   load       append in_data this cycle
//   buf_next   updated buffer
//   fill_next  updated fill; saturates at 0 if c exceeds fill
module quic_bitbuf_shift
  import quic_dec_pkg::*;
(
  input  logic [QUIC_BUF_W-1:0]  buf_cur,
  input  logic [QUIC_FILL_W-1:0] fill,
  input  logic [QUIC_LEN_W-1:0]  c,
  input  logic [QUIC_WORD_W-1:0] in_data,
  input  logic                   load,
  output logic [QUIC_BUF_W-1:0]  buf_next,
  output logic [QUIC_FILL_W-1:0] fill_next
);

  logic [QUIC_FILL_W-1:0] c_ext;
  logic [QUIC_FILL_W-1:0] keep;
  logic [QUIC_BUF_W-1:0]  word_pos;

  assign c_ext = {1'b0, c};

  always_comb begin
    // An over-consume only happens while draining; the buffer simply empties.
    keep     = (c_ext > fill) ? '0 : fill - c_ext;
    word_pos = {in_data, {QUIC_WORD_W{1'b0}}} >> keep;
    buf_next = buf_cur << c;
    fill_next = keep;
    if (load) begin
      buf_next  = buf_next | word_pos;
      fill_next = keep + QUIC_FILL_W'(QUIC_WORD_W);
    end
  end

endmodule

// File: rtl/quic_dec_bitwin_ctrl.sv
// quic_dec_bitwin_ctrl
// Bitstream window controller for the QUIC decoder. Buffers 32-bit compressed
// words in a left-aligned 64-bit register and presents the next 32 stream bits
// MSB-first to the golomb/run decode stage, which consumes 0..32 bits a cycle.
//
// Ports:
//   clk, reset_n    rising-edge clock, asynchronous active-low reset
//   dec_set         synchronous clear (quic_dec_set), overrides everything
//   start           begin a stream, only honoured in IDLE
//   in_if           input word stream, slave side
//   consume_len     bits the decoder consumes this cycle (0..32 legal)
//   full            window qualifier
//   window          buf[63:32], MSB is the next stream bit
//   bits_consumed   running total of consumed bits, wraps mod 2^32
//   done            stream fully consumed
//   err             sticky: illegal length, or over-consume while draining
//
// State | Meaning
// IDLE  | waiting for start
// FILL  | under 32 bits buffered, accepting words, window not valid
// RUN   | 32 or more bits buffered, window valid
// DRAIN | last word taken, under 32 bits left, window zero-padded
// DONE  | buffer exhausted, holds until dec_set
module quic_dec_bitwin_ctrl
  import quic_dec_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    dec_set,
  input  logic                    start,
  quic_dec_bitwin_ctrl_if.slave   in_if,
  input  logic [QUIC_LEN_W-1:0]   consume_len,
  output logic                    full,
  output logic [QUIC_WORD_W-1:0]  window,
  output logic [QUIC_WORD_W-1:0]  bits_consumed,
  output logic                    done,
  output logic                    err
);

  quic_bitwin_state_e state_q, state_d;

  logic [QUIC_BUF_W-1:0]  buf_q, buf_d, shift_buf;
  logic [QUIC_FILL_W-1:0] fill_q, fill_d, shift_fill;
  logic                   eos_seen_q, eos_seen_d;
  logic [QUIC_WORD_W-1:0] bits_consumed_q, bits_consumed_d;
  logic                   err_q, err_d;
  logic                   in_ready_q, in_ready_d;
  logic                   full_q, full_d;
  logic                   done_q, done_d;

  logic                   xfer;
  logic                   len_ok;
  logic                   take;
  logic                   underrun;
  logic [QUIC_LEN_W-1:0]  c;

  assign xfer     = in_if.in_valid && in_ready_q;
  assign len_ok   = consume_len_legal(consume_len);
  assign take     = full_q && len_ok;
  assign c        = take ? consume_len : '0;
  assign underrun = take && ({1'b0, consume_len} > fill_q);

  quic_bitbuf_shift u_shift (
    .buf_cur   (buf_q),
    .fill      (fill_q),
    .c         (c),
    .in_data   (in_if.in_data),
    .load      (xfer),
    .buf_next  (shift_buf),
    .fill_next (shift_fill)
  );

  always_comb begin
    state_d         = state_q;
    buf_d           = buf_q;
    fill_d          = fill_q;
    eos_seen_d      = eos_seen_q;
    bits_consumed_d = bits_consumed_q;
    err_d           = err_q;

    if (dec_set) begin
      state_d         = ST_IDLE;
      buf_d           = '0;
      fill_d          = '0;
      eos_seen_d      = 1'b0;
      bits_consumed_d = '0;
      err_d           = 1'b0;
    end else begin
      buf_d           = shift_buf;
      fill_d          = shift_fill;
      eos_seen_d      = eos_seen_q || (xfer && in_if.in_last);
      // An over-consume in DRAIN still counts the full requested length.
      bits_consumed_d = bits_consumed_q + QUIC_WORD_W'(c);
      if ((full_q && !len_ok) || underrun) begin
        err_d = 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (start) state_d = ST_FILL;
        end
        ST_FILL: begin
          if (fill_d >= QUIC_FILL_W'(QUIC_WORD_W)) state_d = ST_RUN;
          else if (eos_seen_d)                     state_d = ST_DRAIN;
        end
        ST_RUN: begin
          if (fill_d < QUIC_FILL_W'(QUIC_WORD_W)) state_d = eos_seen_d ? ST_DRAIN : ST_FILL;
        end
        ST_DRAIN: begin
          if (fill_d == '0) state_d = ST_DONE;
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // Outputs are registered decodes of the next register values, so they are
    // exactly the decode of the current registers once the edge has passed.
    in_ready_d = ((state_d == ST_FILL) || (state_d == ST_RUN)) && !eos_seen_d &&
                 (fill_d <= QUIC_FILL_W'(QUIC_WORD_W));
    full_d     = ((state_d == ST_RUN) && (fill_d >= QUIC_FILL_W'(QUIC_WORD_W))) ||
                 ((state_d == ST_DRAIN) && (fill_d != '0));
    done_d     = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= ST_IDLE;
      buf_q           <= '0;
      fill_q          <= '0;
      eos_seen_q      <= 1'b0;
      bits_consumed_q <= '0;
      err_q           <= 1'b0;
      in_ready_q      <= 1'b0;
      full_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      buf_q           <= buf_d;
      fill_q          <= fill_d;
      eos_seen_q      <= eos_seen_d;
      bits_consumed_q <= bits_consumed_d;
      err_q           <= err_d;
      in_ready_q      <= in_ready_d;
      full_q          <= full_d;
      done_q          <= done_d;
    end
  end

  assign in_if.in_ready = in_ready_q;
  assign full           = full_q;
  assign window         = buf_q[QUIC_BUF_W-1:QUIC_WORD_W];
  assign bits_consumed  = bits_consumed_q;
  assign done           = done_q;
  assign err            = err_q;

endmodule

// File: doc/quic_dec_bitwin_ctrl.md
# quic_dec_bitwin_ctrl

Bitstream window controller for the QUIC decoder. It accepts 32-bit compressed words from the input word stream and keeps a left-aligned 64-bit bit buffer. It presents a 32-bit MSB-first window to the golomb/run decode logic and drives the `full` qualifier that advances the decoder bit program counter. It consumes 0..32 bits per cycle, as reported by the decode stage, and tracks the total number of bits consumed.

## Interface
- No parameters; all widths are fixed by the QUIC word format.
- Reset is `reset_n`, asynchronous, active-low; the clock is `clk`.
- `clk` in 1: rising-edge clock.
- `reset_n` in 1: asynchronous active-low reset.
- `dec_set` in 1: synchronous clear, equivalent to the quic_dec_set state. It has priority over every other input.
- `start` in 1: pulse that begins a stream; honoured only in IDLE.
- `in_valid` in 1: input word valid.
- `in_data` in 32: input word, first bit in bit 31.
- `in_last` in 1: marks the final word of the stream; sampled only on a transfer.
- `in_ready` out 1: the controller can accept a word this cycle.
- `consume_len` in 6: bits consumed this cycle; legal range 0..32.
- `full` out 1: window valid.
- `window` out 32: bits `buf[63:32]`, MSB is the next stream bit.
- `bits_consumed` out 32: running total of consumed bits, wrapping modulo 2^32.
- `done` out 1: the stream is fully consumed.
- `err` out 1: sticky error. It is set by `consume_len` > 32, or by a consume larger than `fill` while in DRAIN.

## Operation
- Internal state:
  - `buf[63:0]`: left-aligned bit buffer.
  - `fill[6:0]`: number of valid bits, 0..64.
  - `eos_seen`: the last word has been accepted.
  - state machine: IDLE, FILL, RUN, DRAIN, DONE.
- A transfer occurs when `in_valid && in_ready`.
- A consume is honoured only when `full` = 1 and `consume_len` <= 32. When honoured, `c = consume_len`; otherwise `c = 0`.
- Update on a cycle with a transfer:
  - `buf_next = (buf << c) | ({in_data,32'b0} >> (fill - c))`
  - `fill_next = fill - c + 32`
- Update on a cycle without a transfer:
  - `buf_next = buf << c`
  - `fill_next = fill - c`
- Bits of `buf` below position `64 - fill` are always zero, so padding in DRAIN is zeros.
- `in_ready = (state == FILL || state == RUN) && !eos_seen && fill <= 32`. It is decoded from registers only.
- `full`:
  - In RUN: `fill >= 32`.
  - In DRAIN: `fill > 0`.
  - In all other states: 0.
- `bits_consumed += c` on every honoured consume.
- Error handling:
  - `consume_len` > 32 while `full`: set `err`; `c = 0`.
  - In DRAIN, a consume with `c > fill`: `fill_next = 0`, set `err`, and `bits_consumed` still adds `c`.
- State transitions:
  - IDLE: on `start`, go to FILL.
  - FILL: when `fill_next >= 32`, go to RUN. When `eos_seen_next` and `fill_next < 32`, go to DRAIN.
  - RUN: when `fill_next < 32` and not `eos_seen_next`, go to FILL. When `eos_seen_next` and `fill_next < 32`, go to DRAIN.
  - DRAIN: when `fill_next == 0`, go to DONE.
  - DONE: holds until `dec_set`. `done` = 1 only in DONE.
- `dec_set`:
  - Clears `buf`, `fill`, `eos_seen`, `bits_consumed` and `err`.
  - Returns the state machine to IDLE.
  - Ignores any same-cycle transfer or consume.

## Timing
- Reset values: `in_ready` 0, `full` 0, `window` 0, `bits_consumed` 0, `done` 0, `err` 0, state IDLE.
- All outputs are functions of registers only. There is no combinational path from input to output.
- Latency:
  - A word accepted in cycle N contributes to `window` in cycle N+1.
  - From `start` to the first `full` = 1 takes at least 3 cycles: IDLE→FILL, then one word, then a second cycle of fill reaching 32.
- A consume and a transfer in the same cycle are both applied. The new word lands after the remaining `fill - c` bits.
- `in_last` on a transfer sets `eos_seen` at the next edge. `in_ready` drops in that same next cycle.
- Asserting `reset_n` low mid-stream discards the buffer immediately. No partial word is retained.

## Structure
- Shared package `quic_dec_pkg`:
  - state encoding constants for IDLE, FILL, RUN, DRAIN and DONE;
  - `QUIC_WORD_W` = 32;
  - `QUIC_MAX_CONSUME` = 32.
- The module has one sub-module, `quic_bitbuf_shift`: the combinational 64-bit shift/merge datapath. Its inputs are `buf`, `fill`, `c`, `in_data` and the load flag; its outputs are `buf_next` and `fill_next`. The FSM and counters stay in the top module.

## Test plan
- Basic fill: `start`, then words 0xA5A5A5A5 and 0x0F0F0F0F, with `consume_len` = 0.
  - `full` rises with `window` = 0xA5A5A5A5.
- Consume 4 bits once.
  - Next `window` = 0x5A5A5A50 | 0x0 = 0x5A5A5A50.
  - `bits_consumed` = 4.
- Simultaneous consume 32 and transfer at `fill` = 32.
  - `fill` stays 32.
  - `window` equals the new word.
  - `in_ready` stays 1.
- Stream 3 words with `in_last` on the third, consuming 7 bits per cycle.
  - The state machine enters DRAIN.
  - `window` is zero-padded in DRAIN.
  - `done` = 1 after 96 consumed bits.
  - `bits_consumed` = 98, `err` = 1 on the final over-consume (14 cycles × 7 = 98 > 96).
- `consume_len` = 40 while `full`.
  - `err` = 1.
  - `fill`, `window` and `bits_consumed` are unchanged.
- Mid-stream `dec_set`, then mid-stream `reset_n` low.
  - In both cases all outputs return to their reset values and the state machine is in IDLE.
